// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads MEMORY port 1 asynchronously and
// buffers {instruction, pc} pairs in a small prefetch FIFO feeding decode.
module fetch_unit #(
  parameter int                           WORD_SIZE_BYTES = 4,
  parameter logic [WORD_SIZE_BYTES*8-1:0] RESET_PC        = 32'h0000_0000,
  parameter int                           FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [WORD_SIZE_BYTES*8-1:0] memory_address1,
  input  logic [WORD_SIZE_BYTES*8-1:0] memory_data1,
  input  logic                         redirect_valid,
  input  logic [WORD_SIZE_BYTES*8-1:0] redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_SIZE_BYTES*8-1:0] out_instruction,
  output logic [WORD_SIZE_BYTES*8-1:0] out_pc
);

  localparam int AW    = WORD_SIZE_BYTES * 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [AW-1:0]    STEP       = AW'(WORD_SIZE_BYTES);
  localparam logic [AW-1:0]    ALIGN_MASK = ~(AW'(WORD_SIZE_BYTES - 1));

  logic [AW-1:0]    fetch_pc;
  logic [AW-1:0]    fifo_instr [FIFO_DEPTH];
  logic [AW-1:0]    fifo_pc    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             deq;
  logic             enq;

  // Handshake: a transfer to decode happens on a posedge where out_valid and
  // out_ready are both high; out_valid and the head payload are held stable
  // until that transfer, and never depend combinationally on out_ready or
  // redirect_valid. A transfer coinciding with a redirect still completes.
  assign out_valid       = (count != '0);
  assign out_instruction = out_valid ? fifo_instr[rd_ptr] : '0;
  assign out_pc          = out_valid ? fifo_pc[rd_ptr]    : '0;
  assign memory_address1 = fetch_pc;

  assign deq = out_valid & out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign enq = !redirect_valid & ((count < DEPTH_C) | deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ALIGN_MASK;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + STEP;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (enq && !reset) begin
      fifo_instr[wr_ptr] <= memory_data1;
      fifo_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory on port 1 and a
// scoreboard of expected {pc, instruction} pairs per fetch segment.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memory_address1;
  logic [31:0] memory_data1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  logic [63:0] exp_q[$];
  int          n_tests   = 0;
  int          n_fail    = 0;
  int          delivered = 0;

  fetch_unit #(
    .WORD_SIZE_BYTES(4),
    .RESET_PC       (32'h0000_0000),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .memory_address1(memory_address1),
    .memory_data1   (memory_data1),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Memory preload: word k holds 32'h1000_0000 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign memory_data1 = mem_word(memory_address1);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // A new fetch segment replaces all pending expectations.
  task automatic start_segment(input logic [31:0] base);
    logic [31:0] pc;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      pc = base + 32'(4 * i);
      exp_q.push_back({pc, mem_word(pc)});
    end
  endtask

  // One clock: score any transfer happening at this edge, then advance.
  task automatic cycle();
    logic [63:0] e;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_empty: got pc %h with no expected entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("deq_pair", {out_pc, out_instruction}, e);
        delivered++;
      end
    end
    if (reset) start_segment(32'h0000_0000);
    else if (redirect_valid) start_segment(redirect_pc & ~32'h3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // reset then streaming with out_ready high
    cycle();
    cycle();
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_instr", {32'd0, out_instruction}, 64'd0);
    check("rst_pc", {32'd0, out_pc}, 64'd0);
    check("rst_addr", {32'd0, memory_address1}, 64'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    check("pre_valid", {63'd0, out_valid}, 64'd0);
    cycle();
    check("first_valid", {63'd0, out_valid}, 64'd1);
    check("first_pc", {32'd0, out_pc}, 64'd0);
    for (int i = 0; i < 12; i++) begin
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      cycle();
    end

    // backpressure: fill and hold
    reset = 1'b1;
    cycle();
    reset     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    check("full_addr", {32'd0, memory_address1}, 64'd16);
    check("full_valid", {63'd0, out_valid}, 64'd1);
    check("full_head_pc", {32'd0, out_pc}, 64'd0);
    check("full_head_instr", {32'd0, out_instruction}, 64'h1000_0000);

    // three-cycle ready pulse while full
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    out_ready = 1'b0;
    check("pulse_addr", {32'd0, memory_address1}, 64'd28);
    cycle();
    cycle();
    check("pulse_hold_addr", {32'd0, memory_address1}, 64'd28);
    check("pulse_head_pc", {32'd0, out_pc}, 64'd12);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("resume_valid", {63'd0, out_valid}, 64'd1);
      cycle();
    end

    // redirect with three entries queued
    out_ready = 1'b0;
    reset     = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("q3_addr", {32'd0, memory_address1}, 64'd12);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    check("redir_valid0", {63'd0, out_valid}, 64'd0);
    check("redir_addr", {32'd0, memory_address1}, 64'h100);
    cycle();
    check("redir_valid1", {63'd0, out_valid}, 64'd1);
    check("redir_pc", {32'd0, out_pc}, 64'h100);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // wrap-around target, transfer coinciding with the redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    // back-to-back redirects: only the last survives
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    cycle();
    redirect_pc = 32'h0000_0300;
    cycle();
    redirect_valid = 1'b0;
    check("b2b_addr", {32'd0, memory_address1}, 64'h300);
    cycle();
    check("b2b_pc", {32'd0, out_pc}, 64'h300);
    for (int i = 0; i < 4; i++) cycle();

    // one-cycle reset mid-stream with the FIFO full
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_instr", {32'd0, out_instruction}, 64'd0);
    check("mrst_pc", {32'd0, out_pc}, 64'd0);
    check("mrst_addr", {32'd0, memory_address1}, 64'd0);
    out_ready = 1'b1;
    cycle();
    check("mrst_first_pc", {32'd0, out_pc}, 64'd0);
    for (int i = 0; i < 5; i++) cycle();

    check("delivered_min", {63'd0, (delivered >= 25)}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
